// File: rtl/stepper_move_sequencer.sv
// Move-command queue and issue sequencer for one stepper_driver (start/dir/steps/done).
// Optional timeout fault on the driver handshake is enabled by defining SEQ_TIMEOUT_EN.
module stepper_move_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_dir,
  input  logic [7:0]                  cmd_steps,
  input  logic                        flush,
  output logic                        drv_start,
  output logic                        drv_dir,
  output logic [7:0]                  drv_steps,
  input  logic                        drv_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic [15:0]                 moves_done,
  output logic                        fault
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int LW          = AW + 1;
  localparam int SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    SETTLE
`ifdef SEQ_TIMEOUT_EN
    , FAULT
`endif
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [8:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            done_seen;
  logic [SW-1:0]   settle_cnt;

  // flush wins over a same-cycle push so a flushed queue is truly empty afterwards
  assign cmd_ready = (level < LW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready && !flush;
  assign busy      = (state != IDLE) || (level != '0);

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    done_seen  = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0 && !flush) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: next_state = WAIT_ACK;
      WAIT_ACK: begin
        // done may be low for a single cycle on a zero-step move, so it is checked every cycle
        if (!drv_done) begin
          next_state = WAIT_DONE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
          next_state = FAULT;
        end
`endif
      end
      WAIT_DONE: begin
        if (drv_done) begin
          done_seen  = 1'b1;
          next_state = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
          next_state = FAULT;
        end
`endif
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          next_state = IDLE;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      FAULT: next_state = FAULT;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      drv_start  <= 1'b0;
      drv_dir    <= 1'b0;
      drv_steps  <= '0;
      moves_done <= '0;
      settle_cnt <= '0;
    end else begin
      state     <= next_state;
      drv_start <= (next_state == START);
      if (pop) begin
        {drv_dir, drv_steps} <= fifo_mem[rd_ptr];
      end
      if (done_seen) begin
        moves_done <= moves_done + 16'd1;
      end
      if (done_seen) begin
        settle_cnt <= SW'(SETTLE_LOAD);
      end else if (state == SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // storage needs no reset; pointers and level define what is valid
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_dir, cmd_steps};
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // one budget covers the whole acknowledge-plus-completion handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      if (state == START) begin
        to_cnt <= '0;
      end else if (state == WAIT_ACK || state == WAIT_DONE) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (next_state == FAULT) begin
        fault <= 1'b1;
      end
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer with a behavioural stepper_driver and a
// scoreboard of expected {dir, steps} popped at each drv_start.
module tb_stepper_move_sequencer;

  localparam int DEPTH  = 16;
  localparam int SETTLE = 4;
  localparam int TMO    = 50;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic       flush;
  logic       drv_start;
  logic       drv_dir;
  logic [7:0] drv_steps;
  logic       drv_done = 1'b1;
  logic       busy;
  logic [4:0] level;
  logic [15:0] moves_done;
  logic       fault;

  stepper_move_sequencer #(
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .flush     (flush),
    .drv_start (drv_start),
    .drv_dir   (drv_dir),
    .drv_steps (drv_steps),
    .drv_done  (drv_done),
    .busy      (busy),
    .level     (level),
    .moves_done(moves_done),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int starts = 0;
  int last_start_cyc = 0;
  int last_done_cyc  = 0;
  int push_cyc = 0;
  logic prev_start = 1'b0;
  logic prev_done  = 1'b1;
  logic [8:0] sb[$];
  int gaps[$];

  // driver model: done drops the cycle after start is sampled, rises steps+1 cycles later
  logic       stall = 1'b0;
  logic       model_busy = 1'b0;
  logic [7:0] model_cnt = '0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (drv_start) begin
      model_busy <= 1'b1;
      model_cnt  <= drv_steps;
      drv_done   <= 1'b0;
    end else if (model_busy && model_cnt != 8'd0) begin
      model_cnt <= model_cnt - 8'd1;
    end else if (model_busy && !stall) begin
      model_busy <= 1'b0;
      drv_done   <= 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  always @(negedge clock) begin
    logic [8:0] exp_cmd;
    if (prev_start) check_output("start_width", {31'd0, drv_start}, 32'd0);
    if (drv_done && !prev_done) last_done_cyc = cyc;
    if (drv_start) begin
      starts++;
      last_start_cyc = cyc;
      gaps.push_back(cyc - last_done_cyc);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $error("[TB] FAIL unexpected_start: observed start dir %0d steps %0d, expected no start",
               drv_dir, drv_steps);
      end else begin
        exp_cmd = sb.pop_front();
        check_output("start_dir", {31'd0, drv_dir}, {31'd0, exp_cmd[8]});
        check_output("start_steps", {24'd0, drv_steps}, {24'd0, exp_cmd[7:0]});
      end
    end
    prev_start = drv_start;
    prev_done  = drv_done;
  end

  // called at a negedge; drives one push cycle and returns at the following negedge
  task automatic apply_stimulus(input logic dir, input logic [7:0] steps,
                                input logic expect_accept);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    push_cyc  = cyc;
    check_output("cmd_ready", {31'd0, cmd_ready}, {31'd0, expect_accept});
    if (expect_accept) sb.push_back({dir, steps});
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n = 0;
    while (starts < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_output(tag, starts, target);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int idle_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    idle_cyc = cyc;
    check_output(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_values();
    check_output("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_output("rst_drv_start", {31'd0, drv_start}, 32'd0);
    check_output("rst_drv_dir", {31'd0, drv_dir}, 32'd0);
    check_output("rst_drv_steps", {24'd0, drv_steps}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_level", {27'd0, level}, 32'd0);
    check_output("rst_moves_done", {16'd0, moves_done}, 32'd0);
    check_output("rst_fault", {31'd0, fault}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idle_cyc;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = 8'd0;
    flush     = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] single move");
    apply_stimulus(1'b1, 8'd5, 1'b1);
    wait_starts(1, 20, "t1_start");
    check_output("t1_latency", last_start_cyc - push_cyc, 2);
    wait_idle(100, "t1_idle", idle_cyc);
    check_output("t1_busy_fall", idle_cyc - last_done_cyc, SETTLE + 1);
    check_output("t1_moves_done", {16'd0, moves_done}, 32'd1);
    check_output("t1_dir_held", {31'd0, drv_dir}, 32'd1);
    check_output("t1_steps_held", {24'd0, drv_steps}, 32'd5);

    $display("[TB] back-to-back moves");
    gaps.delete();
    apply_stimulus(1'b0, 8'd3, 1'b1);
    apply_stimulus(1'b1, 8'd0, 1'b1);
    apply_stimulus(1'b0, 8'd7, 1'b1);
    wait_starts(4, 200, "t2_starts");
    wait_idle(100, "t2_idle", idle_cyc);
    check_output("t2_moves_done", {16'd0, moves_done}, 32'd4);
    check_output("t2_gap_count", gaps.size(), 3);
    if (gaps.size() == 3) begin
      check_output("t2_gap_1", gaps[1], SETTLE + 2);
      check_output("t2_gap_2", gaps[2], SETTLE + 2);
    end

    $display("[TB] fill queue while a move runs");
    stall = 1'b1;
    apply_stimulus(1'b0, 8'd2, 1'b1);
    wait_starts(5, 20, "t3_first_start");
    for (int i = 0; i <= DEPTH; i++) begin
      apply_stimulus(i[0], 8'(10 + i), (i < DEPTH));
    end
    check_output("t3_level_full", {27'd0, level}, DEPTH);
    check_output("t3_ready_low", {31'd0, cmd_ready}, 32'd0);
    stall = 1'b0;
    wait_starts(5 + DEPTH, 1500, "t3_all_starts");
    wait_idle(200, "t3_idle", idle_cyc);
    check_output("t3_moves_done", {16'd0, moves_done}, 5 + DEPTH);

    $display("[TB] flush with one move in flight");
    stall = 1'b1;
    apply_stimulus(1'b0, 8'd3, 1'b1);
    wait_starts(6 + DEPTH, 20, "t4_start");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'(40 + i), 1'b1);
    end
    check_output("t4_level_5", {27'd0, level}, 32'd5);
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd99;
    @(negedge clock);
    flush     = 1'b0;
    cmd_valid = 1'b0;
    check_output("t4_level_flushed", {27'd0, level}, 32'd0);
    repeat (5) void'(sb.pop_back());
    stall = 1'b0;
    wait_idle(100, "t4_idle", idle_cyc);
    check_output("t4_moves_done", {16'd0, moves_done}, 6 + DEPTH);
    check_output("t4_starts", starts, 6 + DEPTH);

    $display("[TB] reset during WAIT_DONE");
    stall = 1'b1;
    apply_stimulus(1'b1, 8'd4, 1'b1);
    wait_starts(7 + DEPTH, 20, "t5_start");
    apply_stimulus(1'b0, 8'd6, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    sb.delete();
    stall = 1'b0;
    repeat (10) @(negedge clock);
    check_output("t5_no_reissue", starts, 7 + DEPTH);
    check_output("t5_idle_after", {31'd0, busy}, 32'd0);
    apply_stimulus(1'b0, 8'd9, 1'b1);
    wait_starts(8 + DEPTH, 20, "t5_restart");
    check_output("t5_latency", last_start_cyc - push_cyc, 2);
    wait_idle(100, "t5_idle", idle_cyc);
    check_output("t5_moves_done", {16'd0, moves_done}, 32'd1);

`ifdef SEQ_TIMEOUT_EN
    $display("[TB] handshake timeout");
    begin
      int n = 0;
      stall = 1'b1;
      apply_stimulus(1'b1, 8'd1, 1'b1);
      wait_starts(9 + DEPTH, 20, "t6_start");
      while (fault !== 1'b1 && n < 100) begin
        @(negedge clock);
        n++;
      end
      check_output("t6_fault_delay", cyc - last_start_cyc, TMO + 1);
      apply_stimulus(1'b0, 8'd2, 1'b1);
      repeat (10) @(negedge clock);
      check_output("t6_no_start", starts, 9 + DEPTH);
      check_output("t6_busy", {31'd0, busy}, 32'd1);
      check_output("t6_fault_sticky", {31'd0, fault}, 32'd1);
      check_output("t6_level", {27'd0, level}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_output("t6_fault_cleared", {31'd0, fault}, 32'd0);
      sb.delete();
      stall = 1'b0;
      repeat (5) @(negedge clock);
    end
`else
    check_output("fault_tied_low", {31'd0, fault}, 32'd0);
`endif

    check_output("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
